// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - multi-cycle mul/div launch, wait and write-back sequencer
//
// Detects R-type mul/div instructions, holds the pipeline, launches the shared
// iterative multiply/divide unit with a one-cycle start pulse, waits for its
// ready flag (bounded by MAX_CYCLES), then performs one write-back cycle that
// targets either rd (unit result) or $r30 (status code) before releasing.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   asynchronous active-high reset, returns to IDLE
//   opcode         in   [4:0] current instruction opcode
//   alu_op         in   [4:0] current instruction func/ALU-op field
//   rd             in   [4:0] current instruction destination register
//   md_ready       in   unit result-ready, only looked at in WAIT
//   md_exception   in   unit exception flag, sampled together with md_ready
//   ctrl_mult      out  one-cycle multiply start pulse
//   ctrl_div       out  one-cycle divide start pulse
//   stall          out  freeze PC and instruction register
//   wb_en          out  register-file write enable
//   wb_reg         out  [4:0] register-file write address
//   wb_sel_status  out  0 = write unit result, 1 = write wb_status
//   wb_status      out  [31:0] zero-extended status code for $r30
//   busy           out  high whenever not IDLE

module multdiv_sequencer #(
  parameter int unsigned MAX_CYCLES     = 40,
  parameter int unsigned MUL_STATUS     = 4,
  parameter int unsigned DIV_STATUS     = 5,
  parameter int unsigned TIMEOUT_STATUS = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  opcode,
  input  logic [4:0]  alu_op,
  input  logic [4:0]  rd,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic        wb_sel_status,
  output logic [31:0] wb_status,
  output logic        busy
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;
  localparam logic [4:0] STATUS_REG = 5'd30;

  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t state, state_next;

  logic [CW-1:0] cnt;
  logic [4:0]    rd_q;
  logic          op_is_div;
  logic          exc_q;
  logic          to_q;
  logic          md_op;

  assign md_op = (opcode == OP_RTYPE) && ((alu_op == ALU_MUL) || (alu_op == ALU_DIV));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operation context and wait counter. exc_q/to_q are always rewritten on
  // the way out of WAIT, so nothing stale from an earlier op reaches WB.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      rd_q      <= '0;
      op_is_div <= 1'b0;
      exc_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (md_op) begin
            op_is_div <= (alu_op == ALU_DIV);
            rd_q      <= rd;
          end
        end
        S_START: begin
          cnt <= '0;
        end
        S_WAIT: begin
          if (cnt != CNT_SAT) begin
            cnt <= cnt + CW'(1);
          end
          // Ready takes priority over a timeout in the same cycle.
          if (md_ready) begin
            exc_q <= md_exception;
            to_q  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            exc_q <= 1'b1;
            to_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next    = state;
    ctrl_mult     = 1'b0;
    ctrl_div      = 1'b0;
    stall         = 1'b0;
    wb_en         = 1'b0;
    wb_reg        = 5'd0;
    wb_sel_status = 1'b0;
    wb_status     = 32'd0;
    busy          = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        // Combinational stall keeps the detected instruction in place.
        stall = md_op;
        if (md_op) begin
          state_next = S_START;
        end
      end
      S_START: begin
        stall      = 1'b1;
        ctrl_mult  = ~op_is_div;
        ctrl_div   = op_is_div;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (md_ready || (cnt == CNT_LAST)) begin
          state_next = S_WB;
        end
      end
      S_WB: begin
        if (exc_q) begin
          wb_en         = 1'b1;
          wb_reg        = STATUS_REG;
          wb_sel_status = 1'b1;
          if (to_q) begin
            wb_status = 32'(TIMEOUT_STATUS);
          end else if (op_is_div) begin
            wb_status = 32'(DIV_STATUS);
          end else begin
            wb_status = 32'(MUL_STATUS);
          end
        end else begin
          wb_reg = rd_q;
          wb_en  = (rd_q != 5'd0);
        end
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb/tb_multdiv_sequencer.sv - self-checking bench for multdiv_sequencer
module tb_multdiv_sequencer;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  logic        clock;
  logic        reset;
  logic [4:0]  opcode;
  logic [4:0]  alu_op;
  logic [4:0]  rd;
  logic        md_ready;
  logic        md_exception;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic        stall;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic        wb_sel_status;
  logic [31:0] wb_status;
  logic        busy;

  multdiv_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .opcode        (opcode),
    .alu_op        (alu_op),
    .rd            (rd),
    .md_ready      (md_ready),
    .md_exception  (md_exception),
    .ctrl_mult     (ctrl_mult),
    .ctrl_div      (ctrl_div),
    .stall         (stall),
    .wb_en         (wb_en),
    .wb_reg        (wb_reg),
    .wb_sel_status (wb_sel_status),
    .wb_status     (wb_status),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ready_at: WAIT cycle (1-based) on which md_ready is raised; 0 = never.
  // noise: also raise md_ready/md_exception in the IDLE and START cycles.
  typedef struct {
    bit          is_div;
    logic [4:0]  rd;
    int          ready_at;
    bit          exc;
    bit          noise;
    bit          e_en;
    logic [4:0]  e_reg;
    bit          e_sel;
    logic [31:0] e_status;
    int          e_stalls;
  } vec_t;

  typedef struct packed {
    logic        en;
    logic [4:0]  wreg;
    logic        sel;
    logic [31:0] status;
  } wb_t;

  vec_t tbl[10];
  wb_t  sb[$];
  int   n_cmp;
  int   n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    opcode       = 5'd0;
    alu_op       = ALU_ADD;
    rd           = 5'd0;
    md_ready     = 1'b0;
    md_exception = 1'b0;
  endtask

  // Called just after a rising edge; leaves just after the edge ending WB.
  task automatic run_vec(input int idx, input vec_t v);
    int  stalls = 0;
    int  pm = 0;
    int  pd = 0;
    bit  done = 0;
    bit  quiet = 1;
    wb_t got;
    wb_t expd;
    opcode = 5'd0;
    alu_op = v.is_div ? ALU_DIV : ALU_MUL;
    rd     = v.rd;
    sb.push_back('{en: v.e_en, wreg: v.e_reg, sel: v.e_sel, status: v.e_status});
    for (int k = 0; k < 80 && !done; k++) begin
      if (v.noise && k <= 1) begin
        md_ready     = 1'b1;
        md_exception = 1'b1;
      end else if (v.ready_at != 0 && k == 1 + v.ready_at) begin
        md_ready     = 1'b1;
        md_exception = v.exc;
      end else begin
        md_ready     = 1'b0;
        md_exception = 1'b0;
      end
      @(negedge clock);
      if (stall) stalls++;
      if (ctrl_mult) pm++;
      if (ctrl_div) pd++;
      if (busy && !stall) begin
        got = '{en: wb_en, wreg: wb_reg, sel: wb_sel_status, status: wb_status};
        if (sb.size() == 0) begin
          chk($sformatf("v%0d_unexpected_wb", idx), 32'd1, 32'd0);
        end else begin
          expd = sb.pop_front();
          chk($sformatf("v%0d_wb_en", idx), 32'(got.en), 32'(expd.en));
          chk($sformatf("v%0d_wb_reg", idx), 32'(got.wreg), 32'(expd.wreg));
          chk($sformatf("v%0d_wb_sel_status", idx), 32'(got.sel), 32'(expd.sel));
          chk($sformatf("v%0d_wb_status", idx), got.status, expd.status);
        end
        done = 1;
      end else if (wb_en || wb_sel_status || (wb_status != 32'd0) || (wb_reg != 5'd0)) begin
        quiet = 0;
      end
      @(posedge clock);
      #1;
    end
    if (!done) begin
      chk($sformatf("v%0d_wb_timeout", idx), 32'd0, 32'd1);
    end
    idle_inputs();
    chk($sformatf("v%0d_stall_cycles", idx), 32'(stalls), 32'(v.e_stalls));
    chk($sformatf("v%0d_mult_pulses", idx), 32'(pm), v.is_div ? 32'd0 : 32'd1);
    chk($sformatf("v%0d_div_pulses", idx), 32'(pd), v.is_div ? 32'd1 : 32'd0);
    chk($sformatf("v%0d_outputs_quiet_outside_wb", idx), 32'(quiet), 32'd1);
  endtask

  initial begin
    bit ok;
    n_cmp = 0;
    n_err = 0;
    //            div rd  rdy  exc noise en reg  sel status stalls
    tbl[0] = '{0, 5'd5,  3,  0, 0, 1, 5'd5,  0, 32'd0, 5};
    tbl[1] = '{1, 5'd7,  2,  1, 0, 1, 5'd30, 1, 32'd5, 4};
    tbl[2] = '{0, 5'd9,  1,  1, 1, 1, 5'd30, 1, 32'd4, 3};
    tbl[3] = '{0, 5'd0,  4,  0, 0, 0, 5'd0,  0, 32'd0, 6};
    tbl[4] = '{1, 5'd12, 0,  0, 0, 1, 5'd30, 1, 32'd6, 42};
    tbl[5] = '{1, 5'd12, 40, 0, 0, 1, 5'd12, 0, 32'd0, 42};
    tbl[6] = '{0, 5'd31, 41, 0, 0, 1, 5'd30, 1, 32'd6, 42};
    tbl[7] = '{0, 5'd3,  2,  0, 0, 1, 5'd3,  0, 32'd0, 4};
    tbl[8] = '{0, 5'd4,  1,  0, 0, 1, 5'd4,  0, 32'd0, 3};
    tbl[9] = '{1, 5'd20, 39, 0, 1, 1, 5'd20, 0, 32'd0, 41};

    // Reset state, with and without a mul/div instruction on the inputs.
    reset = 1'b1;
    idle_inputs();
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall_nop", 32'(stall), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_wb_status", wb_status, 32'd0);
    alu_op = ALU_MUL;
    #1;
    chk("rst_stall_follows_decode", 32'(stall), 32'd1);
    chk("rst_no_mult_pulse", 32'(ctrl_mult), 32'd0);
    idle_inputs();
    @(negedge clock);
    #2 reset = 1'b0;
    @(posedge clock);
    #1;

    // Table vectors; 7 and 8 are back-to-back muls to r3 then r4.
    for (int i = 0; i < 10; i++) begin
      run_vec(i, tbl[i]);
    end

    // An add between sequences must not stall or start anything.
    ok = 1;
    for (int i = 0; i < 3; i++) begin
      alu_op = ALU_ADD;
      rd     = 5'd6;
      @(negedge clock);
      if (stall || busy || ctrl_mult || ctrl_div || wb_en) ok = 0;
      @(posedge clock);
      #1;
    end
    chk("add_no_stall", 32'(ok), 32'd1);
    run_vec(10, tbl[7]);

    // Asynchronous reset in the middle of WAIT.
    opcode = 5'd0;
    alu_op = ALU_MUL;
    rd     = 5'd9;
    repeat (4) @(posedge clock);
    #3;
    chk("midwait_busy_before_reset", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("midwait_busy_after_reset", 32'(busy), 32'd0);
    chk("midwait_stall_follows_decode", 32'(stall), 32'd1);
    chk("midwait_outputs_zero",
        32'({ctrl_mult, ctrl_div, wb_en, wb_sel_status}) | 32'(wb_reg) | wb_status, 32'd0);
    idle_inputs();
    #1;
    chk("midwait_stall_nop", 32'(stall), 32'd0);
    @(negedge clock);
    #2 reset = 1'b0;
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      md_ready     = 1'b1;
      md_exception = i[0];
      @(negedge clock);
      if (busy || wb_en || stall || ctrl_mult || ctrl_div) ok = 0;
      @(posedge clock);
      #1;
    end
    idle_inputs();
    chk("late_ready_no_wb", 32'(ok), 32'd1);
    run_vec(11, tbl[0]);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
